// File: rtl/alu_sched.sv
// Shared-ALU scheduler: two valid/ready requesters arbitrated round-robin onto
// one registered ALU, with a single tagged response channel.

module alu #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    input  logic         sgn,
    output logic [N-1:0] y
);
    logic signed [N:0] ext_a;
    logic signed [N:0] ext_b;
    logic signed [N:0] quot;

    // One extra bit makes a single signed divider serve both signednesses,
    // and keeps the most-negative / -1 case from overflowing.
    always_comb begin
        ext_a = {sgn & a[N-1], a};
        ext_b = {sgn & b[N-1], b};
        quot  = '0;
        if (b != '0) begin
            quot = ext_a / ext_b;
        end
    end

    always_comb begin
        y = '0;
        case (op)
            4'b0000: y = a + b;
            4'b0001: y = a - b;
            4'b0010: y = a * b;
            4'b0011: y = quot[N-1:0];
            4'b0100: y = a & b;
            4'b0101: y = a | b;
            4'b0110: y = ~a;
            4'b0111: y = a << b;
            4'b1000: y = a >> b;
            default: y = '0;
        endcase
    end
endmodule

module alu_sched #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid0,
    input  logic         req_valid1,
    output logic         req_ready0,
    output logic         req_ready1,
    input  logic [N-1:0] req_a0,
    input  logic [N-1:0] req_b0,
    input  logic [N-1:0] req_a1,
    input  logic [N-1:0] req_b1,
    input  logic [3:0]   req_op0,
    input  logic [3:0]   req_op1,
    input  logic         req_signed0,
    input  logic         req_signed1,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_result,
    output logic         resp_err,
    output logic         busy,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [3:0]   op_q, op_d;
    logic         sgn_q, sgn_d;
    logic         id_q, id_d;
    logic [N-1:0] result_q, result_d;
    logic         rid_q, rid_d;
    logic         err_q, err_d;

    logic         gnt0, gnt1;
    logic         exec_err;
    logic [N-1:0] alu_y;

    // A transfer happens on a rising edge where valid and ready are both high;
    // ready never waits on anything but the requesters' own valids.
    always_comb begin
        gnt0 = req_valid0 & (~req_valid1 | last_grant_q);
        gnt1 = req_valid1 & (~req_valid0 | ~last_grant_q);
    end

    assign exec_err = ((op_q == 4'b0011) && (b_q == '0)) || (op_q > 4'b1000);

    alu #(.N(N)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .sgn (sgn_q),
        .y   (alu_y)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        sgn_d        = sgn_q;
        id_d         = id_q;
        result_d     = result_q;
        rid_d        = rid_q;
        err_d        = err_q;
        req_ready0   = 1'b0;
        req_ready1   = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset so ready reads 0 while reset is held.
                req_ready0 = gnt0 & rst_n;
                req_ready1 = gnt1 & rst_n;
                if (gnt0 || gnt1) begin
                    a_d          = gnt0 ? req_a0 : req_a1;
                    b_d          = gnt0 ? req_b0 : req_b1;
                    op_d         = gnt0 ? req_op0 : req_op1;
                    sgn_d        = gnt0 ? req_signed0 : req_signed1;
                    id_d         = gnt1;
                    last_grant_d = gnt1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                result_d = exec_err ? '0 : alu_y;
                rid_d    = id_q;
                err_d    = exec_err;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            sgn_q        <= 1'b0;
            id_q         <= 1'b0;
            result_q     <= '0;
            rid_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            sgn_q        <= sgn_d;
            id_q         <= id_d;
            result_q     <= result_d;
            rid_q        <= rid_d;
            err_q        <= err_d;
        end
    end

    assign resp_valid  = (state_q == RESP);
    assign resp_result = result_q;
    assign resp_id     = rid_q;
    assign resp_err    = err_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed cases plus random traffic, checked by a
// monitor against a plain-arithmetic reference model and expected queue.

module tb_alu_sched;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid0 = 1'b0, req_valid1 = 1'b0;
    logic         req_ready0, req_ready1;
    logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [3:0]   req_op0 = '0, req_op1 = '0;
    logic         req_signed0 = 1'b0, req_signed1 = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic         resp_id;
    logic [W-1:0] resp_result;
    logic         resp_err;
    logic         busy;
    logic [1:0]   dbg_state;

    int tests = 0;
    int fails = 0;

    logic [W+1:0] exp_q[$];
    logic         model_idle = 1'b1;
    logic         model_last = 1'b1;
    int           cyc = 0;
    int           resp_cyc = 0;
    logic         rand_on = 1'b0;

    alu_sched #(.N(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid0  (req_valid0),
        .req_valid1  (req_valid1),
        .req_ready0  (req_ready0),
        .req_ready1  (req_ready1),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .req_op0     (req_op0),
        .req_op1     (req_op1),
        .req_signed0 (req_signed0),
        .req_signed1 (req_signed1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_outputs",
                 {req_ready0, req_ready1, resp_valid, resp_id, resp_err, busy, dbg_state, resp_result}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {err, result} from the operation rules with integer arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] op, input logic sgn);
        int     ia, ib;
        longint r;
        logic   e;
        ia = sgn ? int'($signed(a)) : int'(a);
        ib = sgn ? int'($signed(b)) : int'(b);
        r  = 0;
        e  = 1'b0;
        case (op)
            4'd0: r = longint'(ia) + longint'(ib);
            4'd1: r = longint'(ia) - longint'(ib);
            4'd2: r = longint'(ia) * longint'(ib);
            4'd3: if (ib == 0) e = 1'b1; else r = longint'(ia / ib);
            4'd4: r = longint'(a & b);
            4'd5: r = longint'(a | b);
            4'd6: r = longint'(~a);
            4'd7: r = (int'(b) >= W) ? 0 : (longint'(a) << b);
            4'd8: r = (int'(b) >= W) ? 0 : (longint'(a) >> b);
            default: e = 1'b1;
        endcase
        if (e) r = 0;
        return {e, r[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input logic sgn);
        int   n;
        logic rdy;
        n = 0;
        @(posedge clk);
        #1;
        if (id == 0) begin
            req_a0 = a; req_b0 = b; req_op0 = op; req_signed0 = sgn; req_valid0 = 1'b1;
        end else begin
            req_a1 = a; req_b1 = b; req_op1 = op; req_signed1 = sgn; req_valid1 = 1'b1;
        end
        forever begin
            @(negedge clk);
            rdy = (id == 0) ? req_ready0 : req_ready1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: requester %0d never accepted", id);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (id == 0) req_valid0 = 1'b0; else req_valid1 = 1'b0;
    endtask

    task automatic expect_resp(input logic id, input logic [W-1:0] res, input logic err);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 10);
        check("latency", n, 2);
        check("dir_id", resp_id, id);
        check("dir_result", resp_result, res);
        check("dir_err", resp_err, err);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        check("drain_idle", busy, 0);
    endtask

    task automatic rand_loop(input int id, input int count);
        logic [W-1:0] a, b;
        logic [3:0]   op;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a  = W'($urandom);
            op = 4'($urandom_range(0, 11));
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = W'($urandom_range(0, 9));
                default: b = W'($urandom);
            endcase
            send(id, a, b, op, 1'($urandom_range(0, 1)));
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic         g0, g1;
        logic         exp_rv;
        logic [W:0]   m;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                model_idle = 1'b1;
                model_last = 1'b1;
                check("reset_hold",
                      {req_ready0, req_ready1, resp_valid, resp_id, resp_err, busy, resp_result}, 0);
                continue;
            end
            exp_rv = !model_idle && (cyc >= resp_cyc);
            check("busy", busy, !model_idle);
            check("resp_valid", resp_valid, exp_rv);
            g0 = model_idle && req_valid0 && (!req_valid1 || model_last);
            g1 = model_idle && req_valid1 && !g0;
            check("req_ready", {req_ready0, req_ready1}, {g0, g1});
            if (exp_rv && exp_q.size() > 0) begin
                check("resp", {resp_id, resp_err, resp_result}, exp_q[0]);
                if (resp_ready) begin
                    void'(exp_q.pop_front());
                    model_idle = 1'b1;
                end
            end
            if (g0 || g1) begin
                m = g0 ? model(req_a0, req_b0, req_op0, req_signed0)
                       : model(req_a1, req_b1, req_op1, req_signed1);
                exp_q.push_back({g1, m});
                model_last = g1;
                model_idle = 1'b0;
                resp_cyc   = cyc + 2;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [W+1:0] held;
        int           n;
        do_reset();

        // signed add
        send(0, 8'hFB, 8'h03, 4'b0000, 1'b1);
        expect_resp(1'b0, 8'hFE, 1'b0);
        // divide by zero and illegal opcode
        send(1, 8'h10, 8'h00, 4'b0011, 1'b0);
        expect_resp(1'b1, 8'h00, 1'b1);
        send(1, 8'h10, 8'h00, 4'b1010, 1'b0);
        expect_resp(1'b1, 8'h00, 1'b1);
        // width edge cases
        send(0, 8'hFF, 8'hFF, 4'b0010, 1'b0);
        expect_resp(1'b0, 8'h01, 1'b0);
        send(0, 8'h01, 8'h08, 4'b0111, 1'b0);
        expect_resp(1'b0, 8'h00, 1'b0);
        send(0, 8'hF9, 8'h02, 4'b0011, 1'b1);
        expect_resp(1'b0, 8'hFD, 1'b0);
        wait_idle();

        // tie arbitration from a fresh reset
        do_reset();
        fork
            for (int i = 0; i < 4; i++) send(0, 8'h02, 8'h03, 4'b0010, 1'b0);
            for (int i = 0; i < 4; i++) send(1, 8'h10, 8'h04, 4'b1000, 1'b0);
            begin
                int k;
                k = 0;
                for (int c = 0; c < 100 && k < 8; c++) begin
                    @(negedge clk);
                    if (resp_valid && resp_ready) begin
                        check("tie_id", resp_id, k % 2);
                        check("tie_result", resp_result, (k % 2 == 0) ? 8'h06 : 8'h01);
                        k++;
                    end
                end
                check("tie_count", k, 8);
            end
        join
        wait_idle();

        // backpressure with both requesters valid
        resp_ready = 1'b0;
        fork
            send(0, 8'h21, 8'h12, 4'b0000, 1'b0);
            send(1, 8'h0F, 8'hF0, 4'b0101, 1'b0);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!resp_valid && n < 10);
                held = {resp_id, resp_err, resp_result};
                check("bp_first_id", resp_id, 0);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold", {resp_valid, resp_id, resp_err, resp_result}, {1'b1, held});
                    check("bp_ready", {req_ready0, req_ready1}, 0);
                end
                @(posedge clk);
                #1 resp_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("bp_idle", dbg_state, 0);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!resp_valid && n < 10);
                check("bp_next_id", resp_id, 1);
                check("bp_next_result", resp_result, 8'hFF);
            end
        join
        wait_idle();

        // reset during EXEC
        send(0, 8'h05, 8'h03, 4'b0000, 1'b0);
        #1 rst_n = 1'b0;
        #1 check("rst_exec_outputs",
                 {req_ready0, req_ready1, resp_valid, resp_id, resp_err, busy, resp_result}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_stale", resp_valid, 0);
        send(1, 8'h07, 8'h02, 4'b0001, 1'b0);
        expect_resp(1'b1, 8'h05, 1'b0);
        wait_idle();

        // random traffic with random backpressure
        rand_on = 1'b1;
        fork
            begin
                fork
                    rand_loop(0, 40);
                    rand_loop(1, 40);
                join
                rand_on = 1'b0;
            end
            while (rand_on) begin
                @(posedge clk);
                #1 resp_ready = ($urandom_range(0, 3) != 0);
            end
        join
        #1 resp_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_sched.md
# alu_sched

Shared-ALU scheduler. Two requesters submit operations over valid/ready channels. The block arbitrates between them round-robin, registers the winning operands, and drives one internal `alu` instance. It returns the registered result on a single response channel tagged with the requester id. It sits between the instruction-issue logic and the ALU, so one ALU serves two clients.

## Interface
- `N`, default 8: operand/result width, passed to the internal `alu`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid0`, `req_valid1` in 1: requester 0/1 has an operation.
- `req_ready0`, `req_ready1` out 1: scheduler accepts requester 0/1 this cycle.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in N: operands per requester.
- `req_op0`, `req_op1` in 4: ALU opcode.
  - 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 not a, 0111 shl, 1000 shr.
- `req_signed0`, `req_signed1` in 1: signed arithmetic select.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer takes response.
- `resp_id` out 1: requester that issued the response.
- `resp_result` out N: ALU result, low N bits.
- `resp_err` out 1: divide-by-zero or illegal opcode.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Grant logic: if exactly one `req_valid` is high, grant it. If both are high, grant the requester that is not `last_grant`.
  - `req_ready` is high only for the granted requester, combinationally. It may depend on `req_valid`.
  - On handshake, capture a, b, op, signed and id into operand registers, update `last_grant`, and go to EXEC.
- **EXEC** (exactly 1 cycle)
  - The `alu` sees the registered operands.
  - At the clock edge, capture the ALU output into `resp_result` and set `resp_id`.
  - Set `resp_err` when op = 0011 with b = 0, or when op > 1000.
  - When `resp_err` is set, capture `resp_result` as 0 instead of the ALU output.
  - Go to RESP.
- **RESP**
  - `resp_valid` = 1. `resp_result`, `resp_id` and `resp_err` are held stable.
  - Both `req_ready` outputs are 0.
  - When `resp_ready` = 1, return to IDLE at the edge.
- Width rules:
  - mul: result truncated to the low N bits.
  - Shifts use the full N-bit b; a shift amount ≥ N yields 0.
  - Signed div truncates toward zero.
- Requesters must hold their inputs stable while valid and not ready. The scheduler never drops an accepted request.
- `last_grant` resets to 1, so requester 0 wins the first tie.

## Timing
- Reset values:
  - all `req_ready` = 0, `resp_valid` = 0, `resp_result` = 0, `resp_id` = 0, `resp_err` = 0, `busy` = 0;
  - state = IDLE, `last_grant` = 1.
- Reset asserted mid-operation (EXEC or RESP): the in-flight operation is discarded and no response is issued.
- Latency: handshake at edge E0 → EXEC → result registered at E1 → `resp_valid` high in the cycle after E1 (2 cycles from accept).
- Throughput: at most one operation per 3 cycles.
  - The `resp_ready` handshake edge returns to IDLE.
  - A new accept is possible in the next cycle, not the same cycle.
- Backpressure: `resp_valid` stays high indefinitely until `resp_ready`. No new request is accepted while in RESP.
- Simultaneous valids: after a tie, grants strictly alternate 0, 1, 0, 1 as long as both stay valid.
- `busy` is registered from state: 1 in EXEC and RESP.

## Test plan
- **Signed add:** reset; req0 a=0xFB, b=0x03, op=0000, signed=1 → `resp_valid` 2 cycles after accept, `resp_result`=0xFE, `resp_id`=0, `resp_err`=0.
- **Tie arbitration:** both valid every cycle, resp_ready=1.
  - Stimulus: req0 a=0x02, b=0x03, op=0010; req1 a=0x10, b=0x04, op=1000.
  - Response order: id 0 (0x06), id 1 (0x01), id 0, id 1.
- **Divide by zero:** req1 a=0x10, b=0x00, op=0011 → `resp_err`=1, `resp_result`=0x00, `resp_id`=1. Repeat with op=1010 → `resp_err`=1, `resp_result`=0x00.
- **Backpressure:** `resp_ready`=0 for 5 cycles with both requesters valid → `resp_valid`, result and id stable; `req_ready0` and `req_ready1` stay 0. Raise `resp_ready` → IDLE next cycle, then the other requester is accepted.
- **Reset in EXEC:** assert `rst_n`=0 in the EXEC cycle → all outputs 0 immediately; after release, no stale response; the next request is served normally.
- **Unsigned edge cases:**
  - op=0010 with a=0xFF, b=0xFF → 0x01 (truncation).
  - op=0111 with a=0x01, b=0x08 → 0x00.
  - op=0011 signed with a=0xF9 (−7), b=0x02 → 0xFD (−3).
